// File: rtl/fifo_pkg.sv
// Shared helpers and read-mode constants for the parametrised FIFO family.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2 for sizing pointers; returns 1 for values <= 2.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, contents never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// synchronous flush, sticky overflow/underflow flags and a read-valid strobe.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_STD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [clog2(DEPTH):0]    fifo_words,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_fifo: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_fifo: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("param_fifo: FWFT must be 0 or 1");
  end

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              do_wr;
  logic              do_rd;

  assign full         = (fifo_words == (AW+1)'(DEPTH));
  assign empty        = (fifo_words == '0);
  assign almost_full  = (fifo_words >= (AW+1)'(AF_LEVEL));
  assign almost_empty = (fifo_words <= (AW+1)'(AE_LEVEL));

  // Flush outranks both requests, so neither is accepted in a flush cycle.
  assign do_wr = wr_en & ~full  & ~flush;
  assign do_rd = rd_en & ~empty & ~flush;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_words <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_words <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_words <= fifo_words + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = empty ? '0 : mem_rdata;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else if (flush) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= do_rd;
        if (do_rd) dout_q <= mem_rdata;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: default standard-mode instance plus a 16x4 FWFT instance.
module tb_param_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance (DATA_W=8, DEPTH=8, AF=6, AE=2, standard read)
  logic       fl_a = 0, wr_a = 0, rd_a = 0;
  logic [7:0] din_a = 0, dout_a;
  logic       full_a, af_a, empty_a, ae_a, rv_a, ovf_a, udf_a;
  logic [3:0] words_a;

  // FWFT instance (DATA_W=16, DEPTH=4, AF=2, AE=2)
  logic        fl_b = 0, wr_b = 0, rd_b = 0;
  logic [15:0] din_b = 0, dout_b;
  logic        full_b, af_b, empty_b, ae_b, rv_b, ovf_b, udf_b;
  logic [2:0]  words_b;

  param_fifo u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(fl_a), .wr_en(wr_a), .data_in(din_a),
    .full(full_a), .almost_full(af_a), .rd_en(rd_a), .data_out(dout_a),
    .rd_valid(rv_a), .empty(empty_a), .almost_empty(ae_a), .fifo_words(words_a),
    .overflow(ovf_a), .underflow(udf_a)
  );

  param_fifo #(.DATA_W(16), .DEPTH(4), .FWFT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(fl_b), .wr_en(wr_b), .data_in(din_b),
    .full(full_b), .almost_full(af_b), .rd_en(rd_b), .data_out(dout_b),
    .rd_valid(rv_b), .empty(empty_b), .almost_empty(ae_b), .fifo_words(words_b),
    .overflow(ovf_b), .underflow(udf_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Checks occupancy and the flags that must decode from it (8-deep, AF=6, AE=2).
  task automatic chk_occ_a(input string nm, input int w);
    chk({nm, " words"}, 32'(words_a), 32'(w));
    chk({nm, " full"},  32'(full_a),  32'(w == 8));
    chk({nm, " empty"}, 32'(empty_a), 32'(w == 0));
    chk({nm, " afull"}, 32'(af_a),    32'(w >= 6));
    chk({nm, " aempty"}, 32'(ae_a),   32'(w <= 2));
  endtask

  task automatic cyc_a(input logic f, input logic w, input logic r, input logic [7:0] d);
    fl_a = f; wr_a = w; rd_a = r; din_a = d;
    @(posedge clk); #1;
    fl_a = 0; wr_a = 0; rd_a = 0;
  endtask

  task automatic cyc_b(input logic w, input logic r, input logic [15:0] d);
    wr_b = w; rd_b = r; din_b = d;
    @(posedge clk); #1;
    wr_b = 0; rd_b = 0;
  endtask

  typedef struct {
    logic       fl, wr, rd;
    logic [7:0] din;
    int         words;
    logic [7:0] dout;
    logic       rv, ovf, udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fl, input logic wr, input logic rd, input logic [7:0] din,
                              input int words, input logic [7:0] dout, input logic rv,
                              input logic ovf, input logic udf);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.din = din; v.words = words;
    v.dout = dout; v.rv = rv; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  logic [7:0] q[$];
  logic [7:0] e;

  initial begin
    // fl wr rd din  | words dout rv ovf udf
    tbl.push_back(mk(0,1,0,8'h11, 1,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h12, 2,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h13, 3,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h14, 4,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h15, 5,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h16, 6,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h17, 7,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h18, 8,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,8'h99, 8,8'h00,0,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 7,8'h11,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 6,8'h12,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 5,8'h13,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 4,8'h14,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 3,8'h15,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 2,8'h16,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 1,8'h17,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 0,8'h18,1,1,0));
    tbl.push_back(mk(0,0,1,8'h00, 0,8'h18,0,1,1));
    tbl.push_back(mk(0,0,0,8'h00, 0,8'h18,0,1,1));
    tbl.push_back(mk(1,1,1,8'h55, 0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,8'h00, 0,8'h00,0,0,0));

    // Reset state of both instances
    #3;
    chk_occ_a("rst", 0);
    chk("rst dout_a", 32'(dout_a), 0);
    chk("rst rv_a", 32'(rv_a), 0);
    chk("rst ovf_a", 32'(ovf_a), 0);
    chk("rst udf_a", 32'(udf_a), 0);
    chk("rst empty_b", 32'(empty_b), 1);
    chk("rst dout_b", 32'(dout_b), 0);
    chk("rst rv_b", 32'(rv_b), 0);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    // Tests 1 and 2: fill, overflow, drain, underflow, flush
    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cyc_a(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk_occ_a(nm, tbl[i].words);
      chk({nm, " dout"}, 32'(dout_a), 32'(tbl[i].dout));
      chk({nm, " rv"},   32'(rv_a),   32'(tbl[i].rv));
      chk({nm, " ovf"},  32'(ovf_a),  32'(tbl[i].ovf));
      chk({nm, " udf"},  32'(udf_a),  32'(tbl[i].udf));
    end

    // Test 3: pointer wrap
    for (int i = 0; i < 5; i++) begin
      q.push_back(8'h30 + 8'(i));
      cyc_a(0, 1, 0, 8'h30 + 8'(i));
    end
    for (int i = 0; i < 5; i++) begin
      e = q.pop_front();
      cyc_a(0, 0, 1, 0);
      chk($sformatf("wrapA rd%0d", i), 32'(dout_a), 32'(e));
      chk($sformatf("wrapA rv%0d", i), 32'(rv_a), 1);
    end
    for (int i = 0; i < 8; i++) begin
      q.push_back(8'hA0 + 8'(i));
      cyc_a(0, 1, 0, 8'hA0 + 8'(i));
    end
    chk_occ_a("wrap peak", 8);
    for (int i = 0; i < 8; i++) begin
      e = q.pop_front();
      cyc_a(0, 0, 1, 0);
      chk($sformatf("wrapB rd%0d", i), 32'(dout_a), 32'(e));
    end
    chk_occ_a("wrap end", 0);

    // Test 4: simultaneous read/write at 4, 0 and 8
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'hC0 + 8'(i));
      cyc_a(0, 1, 0, 8'hC0 + 8'(i));
    end
    for (int i = 0; i < 10; i++) begin
      e = q.pop_front();
      q.push_back(8'h40 + 8'(i));
      cyc_a(0, 1, 1, 8'h40 + 8'(i));
      chk($sformatf("simul words%0d", i), 32'(words_a), 4);
      chk($sformatf("simul dout%0d", i), 32'(dout_a), 32'(e));
    end
    for (int i = 0; i < 4; i++) begin
      e = q.pop_front();
      cyc_a(0, 0, 1, 0);
      chk($sformatf("drain dout%0d", i), 32'(dout_a), 32'(e));
    end
    chk_occ_a("drain", 0);
    chk("pre udf", 32'(udf_a), 0);
    q.push_back(8'h77);
    cyc_a(0, 1, 1, 8'h77);
    chk_occ_a("both at 0", 1);
    chk("both at 0 rv", 32'(rv_a), 0);
    chk("both at 0 udf", 32'(udf_a), 1);
    for (int i = 0; i < 7; i++) begin
      q.push_back(8'h80 + 8'(i));
      cyc_a(0, 1, 0, 8'h80 + 8'(i));
    end
    chk_occ_a("fill 8", 8);
    e = q.pop_front();
    cyc_a(0, 1, 1, 8'h88);
    chk_occ_a("both at 8", 7);
    chk("both at 8 dout", 32'(dout_a), 32'(e));
    chk("both at 8 ovf", 32'(ovf_a), 1);
    for (int i = 0; i < 7; i++) begin
      e = q.pop_front();
      cyc_a(0, 0, 1, 0);
      chk($sformatf("post8 dout%0d", i), 32'(dout_a), 32'(e));
    end

    // Test 6: flush at count 5 with overflow set and a write pending
    cyc_a(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc_a(0, 1, 0, 8'h21 + 8'(i));
    cyc_a(0, 1, 0, 8'hFF);
    for (int i = 0; i < 3; i++) cyc_a(0, 0, 1, 0);
    chk_occ_a("pre flush", 5);
    chk("pre flush ovf", 32'(ovf_a), 1);
    chk("pre flush dout", 32'(dout_a), 8'h23);
    cyc_a(1, 1, 0, 8'hEE);
    chk_occ_a("flush", 0);
    chk("flush ovf", 32'(ovf_a), 0);
    chk("flush dout", 32'(dout_a), 0);
    chk("flush rv", 32'(rv_a), 0);

    // Test 5: FWFT instance
    cyc_b(1, 0, 16'hABCD);
    chk("fwft dout", 32'(dout_b), 32'h0000ABCD);
    chk("fwft rv", 32'(rv_b), 1);
    chk("fwft words", 32'(words_b), 1);
    cyc_b(0, 1, 0);
    chk("fwft pop empty", 32'(empty_b), 1);
    chk("fwft pop dout", 32'(dout_b), 0);
    chk("fwft pop rv", 32'(rv_b), 0);
    for (int i = 0; i < 4; i++) cyc_b(1, 0, 16'h1001 + 16'(i));
    chk("fwft full", 32'(full_b), 1);
    chk("fwft head", 32'(dout_b), 32'h1001);
    cyc_b(0, 1, 0);
    chk("fwft next", 32'(dout_b), 32'h1002);
    chk("fwft words3", 32'(words_b), 3);

    // Async reset mid-cycle with live state on both instances
    cyc_a(0, 1, 0, 8'h5A);
    cyc_a(0, 1, 0, 8'h5B);
    cyc_a(0, 0, 1, 0);
    chk("pre rst rv", 32'(rv_a), 1);
    chk("pre rst dout", 32'(dout_a), 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk_occ_a("async rst", 0);
    chk("async rst dout", 32'(dout_a), 0);
    chk("async rst rv", 32'(rv_a), 0);
    chk("async rst words_b", 32'(words_b), 0);
    chk("async rst dout_b", 32'(dout_b), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_occ_a("post rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO and the next generation of the team's 8x8 byte FIFO. Data width, depth, almost-full/almost-empty thresholds and read mode (standard registered or first-word-fall-through) are all configurable. Adds synchronous flush, sticky overflow/underflow error flags and a read-valid strobe. It is the common buffering primitive between producer/consumer blocks on a single clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when fifo_words >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when fifo_words <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents and error flags
wr_en  input  1  write request
data_in  input  DATA_W  write data
full  output  1  fifo_words == DEPTH
almost_full  output  1  fifo_words >= AF_LEVEL
rd_en  input  1  read request; acts as a pop/ack when FWFT=1
data_out  output  DATA_W  read data
rd_valid  output  1  data_out holds newly read data (see Behaviour)
empty  output  1  fifo_words == 0
almost_empty  output  1  fifo_words <= AE_LEVEL
fifo_words  output  AW+1  current occupancy, AW = clog2(DEPTH)
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst_n low, async): pointers=0, fifo_words=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset. Outputs therefore read empty=1, full=0, almost_empty=1, and almost_full=0 (AF_LEVEL>=1).
- Accept rules: do_wr = wr_en & ~full; do_rd = rd_en & ~empty. Both use flag values from before the edge. A write is refused when full even if a read occurs in the same cycle. A read is refused when empty even if a write occurs in the same cycle (no write-through).
- Pointers are AW bits wide and wrap naturally from DEPTH-1 to 0. fifo_words <= fifo_words + do_wr - do_rd. Simultaneous accepted read and write leaves the count unchanged.
- All status flags (full, empty, almost_full, almost_empty) are combinational decodes of the registered fifo_words.
- Standard mode (FWFT=0):
  - On do_rd, data_out <= mem[rd_ptr] at the clock edge, giving 1-cycle latency.
  - rd_valid is registered and equals do_rd from the previous cycle.
  - data_out holds its value when there is no read.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - rd_valid = ~empty, combinational.
  - rd_en pops the displayed word at the edge.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- overflow is set on (wr_en & full); underflow is set on (rd_en & empty). Both hold until flush or reset.
- Flush (synchronous, highest priority in the cycle it is high):
  - pointers=0, fifo_words=0, overflow=0, underflow=0, rd_valid=0.
  - Standard-mode data_out is set to 0.
  - wr_en and rd_en in the same cycle are ignored and do not set the error flags.
- Reset asserted mid-operation clears state immediately, regardless of clk. Deassertion is expected synchronous to clk upstream.

Decomposition:
- Shared package fifo_pkg: clog2 function, mode constants FIFO_STD=0 and FIFO_FWFT=1.
- One sub-module fifo_mem: DEPTH x DATA_W storage with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata), no reset.
- Control, counters, flags and output register live in param_fifo.
- Elaboration-time check: DEPTH is a power of two and the thresholds are within range; otherwise stop with an error.

Test Plan:
1. Defaults, reset then write 0x11..0x18 (8 writes) -> full=1, almost_full from count 6, fifo_words=8. A 9th write sets overflow=1 and count stays 8.
2. Standard mode, read 8 after test 1 -> data_out = 0x11..0x18, each 1 cycle after rd_en, with rd_valid pulsing. A 9th read sets underflow=1, and empty=1, almost_empty=1.
3. Wrap: 5 writes, 5 reads, then 8 writes and 8 reads across pointer wrap -> data returned in order, fifo_words peaks at 8 and returns to 0.
4. Simultaneous wr_en and rd_en at count 4 for 10 cycles -> count stays 4 and order is preserved. At count 0 with both asserted -> only the write is accepted and count becomes 1. At count 8 with both asserted -> only the read is accepted and count becomes 7.
5. FWFT=1, DATA_W=16, DEPTH=4: write 0xABCD into empty FIFO -> data_out=0xABCD and rd_valid=1 the next cycle without rd_en. Pulse rd_en -> empty=1 and data_out=0.
6. Flush at count 5 with overflow set and wr_en=1 -> next cycle count=0, empty=1, overflow=0, write ignored. Async rst_n pulse mid-cycle -> all outputs reset before the next edge.
